// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: converts a sign-magnitude Q7.8 (x, y) pair into
// magnitude and atan2 angle. Each operation takes a fixed 14 cycles from the
// accepted start to the done pulse. Internal arithmetic is 24-bit two's
// complement with 12 fractional bits.
module cordic_vector (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        busy,
  output logic        done,
  output logic [15:0] res1,
  output logic [15:0] res2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned         LAST_ITER = 11;
  // pi at 12 fractional bits (3.14159 * 4096, rounded)
  localparam logic signed [23:0] PI_Z      = 24'sd12868;
  // pi at 8 fractional bits; the angle magnitude is clamped to this
  localparam logic signed [23:0] PI_Q8     = 24'sd804;
  localparam logic signed [23:0] MAG_MAX   = 24'sd32767;

  // Sign-magnitude Q7.8 to two's complement with 12 fractional bits.
  // Negative zero collapses to 0 because negating 0 yields 0.
  function automatic logic signed [23:0] sm_to_tc(input logic [15:0] v);
    logic signed [23:0] m;
    m = {5'd0, v[14:0], 4'd0};
    return v[15] ? -m : m;
  endfunction

  // atan(2^-i) at 12 fractional bits, rounded to nearest.
  function automatic logic signed [23:0] atan_lut(input logic [3:0] i);
    logic signed [23:0] a;
    case (i)
      4'd0:    a = 24'sd3217;
      4'd1:    a = 24'sd1899;
      4'd2:    a = 24'sd1003;
      4'd3:    a = 24'sd509;
      4'd4:    a = 24'sd256;
      4'd5:    a = 24'sd128;
      4'd6:    a = 24'sd64;
      4'd7:    a = 24'sd32;
      4'd8:    a = 24'sd16;
      4'd9:    a = 24'sd8;
      4'd10:   a = 24'sd4;
      4'd11:   a = 24'sd2;
      default: a = 24'sd0;
    endcase
    return a;
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         iter_q;
  logic signed [23:0] xr, yr, zr;
  logic               zero_q;
  logic [15:0]        mag_q, ang_q;
  logic               done_q;
  logic [15:0]        res1_q, res2_q;

  logic signed [23:0] x_in, y_in;
  logic signed [23:0] x_sh, y_sh, atan_i;
  logic signed [23:0] x_nx, y_nx, z_nx;
  logic signed [23:0] x_scl, x_rnd, z_rnd, z_abs;
  logic [15:0]        mag_d, ang_d;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> ITER (12 cycles) -> SCALE -> DONE -> IDLE.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (iter_q == 4'(LAST_ITER)) state_d = SCALE;
      SCALE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand conversion and one micro-rotation; d = +1 when y < 0.
  always_comb begin
    x_in   = sm_to_tc(x);
    y_in   = sm_to_tc(y);
    x_sh   = xr >>> iter_q;
    y_sh   = yr >>> iter_q;
    atan_i = atan_lut(iter_q);
    if (yr[23]) begin
      x_nx = xr - y_sh;
      y_nx = yr + x_sh;
      z_nx = zr - atan_i;
    end else begin
      x_nx = xr + y_sh;
      y_nx = yr - x_sh;
      z_nx = zr + atan_i;
    end
  end

  // Gain compensation, round-half-up to Q7.8 and sign-magnitude encoding.
  always_comb begin
    x_scl = (xr >>> 1) + (xr >>> 3) - (xr >>> 6) - (xr >>> 9);
    x_rnd = (x_scl + 24'sd8) >>> 4;
    z_rnd = (zr + 24'sd8) >>> 4;

    mag_d = 16'h0000;
    if (x_rnd[23])            mag_d = 16'h0000;
    else if (x_rnd > MAG_MAX) mag_d = 16'h7FFF;
    else                      mag_d = {1'b0, x_rnd[14:0]};

    z_abs = z_rnd[23] ? -z_rnd : z_rnd;
    if (z_abs > PI_Q8) z_abs = PI_Q8;

    // A zero vector has no defined angle; report +0. A zero angle is never -0.
    ang_d = 16'h0000;
    if (!zero_q && (z_abs != 24'sd0)) ang_d = {z_rnd[23], z_abs[14:0]};
  end

  // Datapath: operand load with quadrant pre-rotation, iterations, result capture.
  // All registers are cleared by reset so an aborted operation leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_q <= 4'd0;
      xr     <= 24'sd0;
      yr     <= 24'sd0;
      zr     <= 24'sd0;
      zero_q <= 1'b0;
      mag_q  <= 16'h0000;
      ang_q  <= 16'h0000;
      done_q <= 1'b0;
      res1_q <= 16'h0000;
      res2_q <= 16'h0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            iter_q <= 4'd0;
            zero_q <= (x_in == 24'sd0) && (y_in == 24'sd0);
            if (x_in[23]) begin
              // Rotate by pi into the right half-plane and pre-load z with it.
              xr <= -x_in;
              yr <= -y_in;
              zr <= y_in[23] ? -PI_Z : PI_Z;
            end else begin
              xr <= x_in;
              yr <= y_in;
              zr <= 24'sd0;
            end
          end
        end
        ITER: begin
          xr     <= x_nx;
          yr     <= y_nx;
          zr     <= z_nx;
          iter_q <= iter_q + 4'd1;
        end
        SCALE: begin
          mag_q <= mag_d;
          ang_q <= ang_d;
        end
        DONE: begin
          res1_q <= mag_q;
          res2_q <= ang_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign res1 = res1_q;
  assign res2 = res2_q;

endmodule
